ubtb_assoc: RTL
===============

UBTB_ASSOC -- requirements
Module: ubtb_assoc

Interface
REQ-001 Parameter SETS, 4, number of sets; power of two, at least 1.
REQ-002 Parameter WAYS, 4, ways per set; power of two, at least 2.
REQ-003 Parameter SLOTS, 2, branch slots per entry.
REQ-004 Parameter TAG_W, 8, tag width.
REQ-005 Parameter CTR_W, 2, saturating counter width.
REQ-006 Parameter PC_W, 32, address width.
REQ-007 Parameter BLOCK_BYTES, 32, fetch block size; power of two.
REQ-008 Parameter INST_OFF, 1, log2 of instruction granule.
REQ-009 Parameter BYP_DEPTH, 4, depth of the counter bypass queue.
REQ-010 Derived widths: OW = log2(BLOCK_BYTES)-INST_OFF; IW = log2(SETS).
REQ-011 clk, input, 1, clock.
REQ-012 rst, input, 1, reset; asynchronous, active-high.
REQ-013 lk_valid, input, 1, lookup request.
REQ-014 lk_pc, input, PC_W, fetch block start address.
REQ-015 stall, input, 1, hold the output register.
REQ-016 flush, input, 1, invalidate all entries.
REQ-017 pr_valid, pr_hit, output, 1 each, prediction valid; tag hit.
REQ-018 pr_taken, output, 1, a slot predicts taken.
REQ-019 pr_slot, output, log2(SLOTS) min 1, index of the taken slot.
REQ-020 pr_target, output, PC_W, next fetch address.
REQ-021 pr_meta_ctr, output, SLOTS*CTR_W, looked-up counters.
REQ-022 up_valid, up_pc, input, 1 and PC_W, update request and block address.
REQ-023 up_slot_en, input, SLOTS, slot valid mask.
REQ-024 up_offset, input, SLOTS*OW, per-slot offset.
REQ-025 up_target, input, SLOTS*PC_W, per-slot target.
REQ-026 up_taken, up_alloc, input, SLOTS each, resolved direction; newly allocated slot.
REQ-027 up_meta_ctr, input, SLOTS*CTR_W, counters captured at prediction.

Function
REQ-028 Address split: set = pc[BO+:IW] and tag = pc[BO+IW+:TAG_W], where BO = log2(BLOCK_BYTES); when SETS==1, set = 0.
REQ-029 An entry holds valid, tag, per-slot {en, offset, target}, and per-slot counters.
REQ-030 Lookup hit: exactly one valid way in the indexed set matches the tag; multiple matches are prevented by update rules.
REQ-031 Taken slot: lowest-index slot with en=1 and counter MSB=1; pr_taken=0 when no slot qualifies or on a miss.
REQ-032 pr_target = target of the taken slot; otherwise (lk_pc aligned down to BLOCK_BYTES) + BLOCK_BYTES, truncated modulo 2^PC_W.
REQ-033 Latency: outputs are registered one cycle after lk_valid; with stall=1 all pr_* hold and the new lookup is dropped.
REQ-034 pr_valid = registered lk_valid; it deasserts the cycle after a lookup-free, non-stalled cycle.
REQ-035 On update, the target way is the hit way in the indexed set; otherwise the PLRU victim, preferring the lowest-index invalid way.
REQ-036 On update, the written entry gets valid=1, new tag, and slot fields from the up_* inputs.
REQ-037 Counter source: the youngest bypass queue entry matching {set, way}; otherwise up_meta_ctr.
REQ-038 Per slot with up_slot_en=1: if up_alloc=1, counter = 2^(CTR_W-1) (weak taken); otherwise saturating increment if taken, else saturating decrement.
REQ-039 Per slot with up_slot_en=0: counter is written as the selected source unchanged.
REQ-040 Bypass queue: circular, BYP_DEPTH entries of {set, way, counters}.
REQ-041 Every update pushes one bypass entry, overwriting the oldest when full; it never stalls.
REQ-042 PLRU is a tree per set; it is touched by a lookup hit (registered cycle) and by an update.
REQ-043 When a lookup hit and an update touch the same set in one cycle, the update wins.
REQ-044 Simultaneous lookup and update to the same entry: the lookup sees pre-update contents; the update is visible next cycle.
REQ-045 flush clears all valid bits and bypass valids in one cycle; PLRU state is retained.
REQ-046 flush takes priority over an update in the same cycle.

Reset
REQ-047 rst clears all valid bits, counters, PLRU state, bypass valids and pointers, and all pr_* outputs to 0.
REQ-048 Reset is asynchronous and may arrive mid-operation; the first lookup after release misses.

Verification
REQ-049 Reset, then lookup 0x1000 -> next cycle pr_valid=1, pr_hit=0, pr_target=0x1020.
REQ-050 Update 0x1000, slot0 en/alloc/taken, offset 3, target 0x2000; lookup 0x1000 -> pr_hit=1, pr_slot=0, pr_target=0x2000, meta ctr0=2.
REQ-051 Two not-taken updates to that slot with meta ctr=2 and no bypass clear -> ctr reaches 0; lookup -> pr_taken=0, pr_target=0x1020.
REQ-052 Fill WAYS+1 distinct tags in set 0 without lookups -> way 0 replaced, oldest tag misses, the others hit.
REQ-053 Update and lookup of the same block in one cycle -> that lookup misses and the next lookup hits; stall held for 3 cycles -> pr_* unchanged.
REQ-054 flush together with an update -> every lookup misses; assert rst during an update -> all outputs 0 immediately.

Source files
------------

// File: rtl/ubtb_assoc.sv
// ubtb_assoc: set-associative micro-BTB with PLRU replacement and a counter bypass queue
//   clk, rst (async, active-high)
//   lk_valid/lk_pc: lookup request; stall holds pr_*; flush invalidates all entries
//   pr_valid/pr_hit/pr_taken/pr_slot/pr_target/pr_meta_ctr: registered prediction
//   up_valid/up_pc/up_slot_en/up_offset/up_target/up_taken/up_alloc/up_meta_ctr: training update
module ubtb_assoc #(
  parameter int SETS = 4,
  parameter int WAYS = 4,
  parameter int SLOTS = 2,
  parameter int TAG_W = 8,
  parameter int CTR_W = 2,
  parameter int PC_W = 32,
  parameter int BLOCK_BYTES = 32,
  parameter int INST_OFF = 1,
  parameter int BYP_DEPTH = 4,
  localparam int BO = $clog2(BLOCK_BYTES),
  localparam int OW = BO - INST_OFF,
  localparam int IW = SETS > 1 ? $clog2(SETS) : 1,
  localparam int SW = SLOTS > 1 ? $clog2(SLOTS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     lk_valid,
  input  logic [PC_W-1:0]          lk_pc,
  input  logic                     stall,
  input  logic                     flush,
  output logic                     pr_valid,
  output logic                     pr_hit,
  output logic                     pr_taken,
  output logic [SW-1:0]            pr_slot,
  output logic [PC_W-1:0]          pr_target,
  output logic [SLOTS*CTR_W-1:0]   pr_meta_ctr,
  input  logic                     up_valid,
  input  logic [PC_W-1:0]          up_pc,
  input  logic [SLOTS-1:0]         up_slot_en,
  input  logic [SLOTS*OW-1:0]      up_offset,
  input  logic [SLOTS*PC_W-1:0]    up_target,
  input  logic [SLOTS-1:0]         up_taken,
  input  logic [SLOTS-1:0]         up_alloc,
  input  logic [SLOTS*CTR_W-1:0]   up_meta_ctr
);
  localparam int TB = BO + (SETS > 1 ? $clog2(SETS) : 0);
  localparam int WW = $clog2(WAYS);
  localparam int PW = BYP_DEPTH > 1 ? $clog2(BYP_DEPTH) : 1;
  localparam int CW = SLOTS * CTR_W;

  logic [WAYS-1:0]      vld  [SETS];
  logic [TAG_W-1:0]     tag  [SETS][WAYS];
  logic [SLOTS-1:0]     sen  [SETS][WAYS];
  logic [SLOTS*OW-1:0]  off  [SETS][WAYS];
  logic [PC_W-1:0]      tgt  [SETS][WAYS][SLOTS];
  logic [CW-1:0]        ctr  [SETS][WAYS];
  logic [WAYS-2:0]      plru [SETS];
  logic [BYP_DEPTH-1:0] bv;
  logic [IW-1:0]        bset [BYP_DEPTH];
  logic [WW-1:0]        bway [BYP_DEPTH];
  logic [CW-1:0]        bctr [BYP_DEPTH];
  logic [PW-1:0]        wptr;

  logic [IW-1:0]    lk_set, up_set;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, lk_tk, up_hit, up_inv;
  logic [WW-1:0]    lk_way, up_hway, up_iway, up_way;
  logic [SW-1:0]    lk_sl;
  logic [CW-1:0]    lk_ctr, up_src, up_ctr;
  logic [PC_W-1:0]  lk_tgt;
  logic             unused_bits;

  // tree PLRU: heap node n lives at bit n-1; a bit points toward the less recently used half
  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] b, input logic [WW-1:0] w);
    int n;
    n = 1;
    for (int l = WW - 1; l >= 0; l--) begin
      b[n-1] = ~w[l];
      n = 2 * n + int'(w[l]);
    end
    return b;
  endfunction

  function automatic logic [WW-1:0] plru_victim(input logic [WAYS-2:0] b);
    int n;
    n = 1;
    for (int l = 0; l < WW; l++) n = 2 * n + int'(b[n-1]);
    return WW'(n - WAYS);
  endfunction

  assign lk_set = SETS > 1 ? lk_pc[BO+:IW] : '0;
  assign up_set = SETS > 1 ? up_pc[BO+:IW] : '0;
  assign lk_tag = lk_pc[TB+:TAG_W];
  assign up_tag = up_pc[TB+:TAG_W];

  always_comb begin
    lk_hit = 1'b0;
    lk_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (vld[lk_set][w] && tag[lk_set][w] == lk_tag) begin
        lk_hit = 1'b1;
        lk_way = WW'(w);
      end
    lk_ctr = lk_hit ? ctr[lk_set][lk_way] : '0;
    lk_tk = 1'b0;
    lk_sl = '0;
    for (int s = SLOTS - 1; s >= 0; s--)
      if (lk_hit && sen[lk_set][lk_way][s] && lk_ctr[s*CTR_W+CTR_W-1]) begin
        lk_tk = 1'b1;
        lk_sl = SW'(s);
      end
    lk_tgt = lk_tk ? tgt[lk_set][lk_way][lk_sl] : {lk_pc[PC_W-1:BO], {BO{1'b0}}} + PC_W'(BLOCK_BYTES);
  end

  always_comb begin
    up_hit = 1'b0;
    up_hway = '0;
    up_inv = 1'b0;
    up_iway = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (vld[up_set][w] && tag[up_set][w] == up_tag) begin
        up_hit = 1'b1;
        up_hway = WW'(w);
      end
      if (!vld[up_set][w]) begin
        up_inv = 1'b1;
        up_iway = WW'(w);
      end
    end
    up_way = up_hit ? up_hway : up_inv ? up_iway : plru_victim(plru[up_set]);
  end

  // scan oldest to youngest so the youngest matching bypass entry wins
  always_comb begin
    logic [PW-1:0] bi;
    logic [CTR_W-1:0] c;
    up_src = up_meta_ctr;
    for (int k = BYP_DEPTH; k >= 1; k--) begin
      bi = PW'((int'(wptr) + BYP_DEPTH - k) % BYP_DEPTH);
      if (bv[bi] && bset[bi] == up_set && bway[bi] == up_way) up_src = bctr[bi];
    end
    up_ctr = '0;
    for (int s = 0; s < SLOTS; s++) begin
      c = up_src[s*CTR_W+:CTR_W];
      up_ctr[s*CTR_W+:CTR_W] = !up_slot_en[s] ? c :
                               up_alloc[s] ? CTR_W'(1) << (CTR_W - 1) :
                               up_taken[s] ? (&c ? c : c + 1'b1) :
                               (~|c ? c : c - 1'b1);
    end
  end

  always_comb begin
    unused_bits = ^{lk_pc, up_pc};
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) unused_bits = unused_bits ^ (^off[s][w]);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pr_valid <= 1'b0;
      pr_hit <= 1'b0;
      pr_taken <= 1'b0;
      pr_slot <= '0;
      pr_target <= '0;
      pr_meta_ctr <= '0;
      bv <= '0;
      wptr <= '0;
      for (int s = 0; s < SETS; s++) begin
        vld[s] <= '0;
        plru[s] <= '0;
        for (int w = 0; w < WAYS; w++) ctr[s][w] <= '0;
      end
    end else begin
      if (!stall) begin
        pr_valid <= lk_valid;
        pr_hit <= lk_valid && lk_hit;
        pr_taken <= lk_valid && lk_tk;
        pr_slot <= lk_sl;
        pr_target <= lk_tgt;
        pr_meta_ctr <= lk_ctr;
      end
      if (flush) begin
        bv <= '0;
        for (int s = 0; s < SETS; s++) vld[s] <= '0;
      end else begin
        // the update's touch is issued last so it wins on a shared set
        if (lk_valid && !stall && lk_hit) plru[lk_set] <= plru_touch(plru[lk_set], lk_way);
        if (up_valid) begin
          plru[up_set] <= plru_touch(plru[up_set], up_way);
          vld[up_set][up_way] <= 1'b1;
          ctr[up_set][up_way] <= up_ctr;
          bv[wptr] <= 1'b1;
          wptr <= wptr == PW'(BYP_DEPTH - 1) ? '0 : wptr + 1'b1;
        end
      end
    end

  always_ff @(posedge clk)
    if (up_valid && !flush) begin
      tag[up_set][up_way] <= up_tag;
      sen[up_set][up_way] <= up_slot_en;
      off[up_set][up_way] <= up_offset;
      for (int s = 0; s < SLOTS; s++) tgt[up_set][up_way][s] <= up_target[s*PC_W+:PC_W];
      bset[wptr] <= up_set;
      bway[wptr] <= up_way;
      bctr[wptr] <= up_ctr;
    end
endmodule
